// File: rtl/seg_arb_pkg.sv
// Shared encodings for the segment bus arbiter: segment codes,
// FSM states and grant bit positions.
package seg_arb_pkg;

    localparam logic [1:0] SEG_ES = 2'b00;
    localparam logic [1:0] SEG_CS = 2'b01;
    localparam logic [1:0] SEG_SS = 2'b10;
    localparam logic [1:0] SEG_DS = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int GNT_FETCH = 0;
    localparam int GNT_STK   = 1;
    localparam int GNT_DAT   = 2;

endpackage

// File: rtl/seg_bus_arbiter_if.sv
// Bus-cycle side of the arbiter: address/request out, ack back,
// plus the grant, segment-used and done status bundle.
interface seg_bus_if;

    logic        bus_req;
    logic [19:0] bus_addr;
    logic        bus_ack;
    logic [2:0]  grant;
    logic [1:0]  seg_used;
    logic [2:0]  done;

    modport master (
        output bus_req,
        output bus_addr,
        output grant,
        output seg_used,
        output done,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_addr,
        input  grant,
        input  seg_used,
        input  done,
        output bus_ack
    );

endinterface

// File: rtl/seg_bus_arbiter_phys_addr_gen.sv
// Real-mode physical address: {seg,4'h0} + {4'h0,ofs}, wrapped to 20 bits.
// Purely combinational so the effective-address unit can reuse it.
module phys_addr_gen (
    input  logic [15:0] seg,
    input  logic [15:0] ofs,
    output logic [19:0] addr
);

    // A 20-bit sum drops the carry out of bit 19, giving the 1 MB wrap.
    assign addr = {seg, 4'h0} + {4'h0, ofs};

endmodule

// File: rtl/seg_bus_arbiter.sv
// Arbitrates prefetch, stack and EU data onto one bus address path.
// Define SEG_ARB_STARVE_GUARD_EN to let a starved fetch jump the queue.
module seg_bus_arbiter
    import seg_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [15:0]   seg_cs,
    input  logic [15:0]   seg_ds,
    input  logic [15:0]   seg_ss,
    input  logic [15:0]   seg_es,
    input  logic          fetch_req,
    input  logic [15:0]   fetch_ofs,
    input  logic          stk_req,
    input  logic [15:0]   stk_ofs,
    input  logic          dat_req,
    input  logic [15:0]   dat_ofs,
    input  logic [1:0]    dat_seg,
    input  logic          ovr_set,
    input  logic [1:0]    ovr_seg,
    seg_bus_if.master     bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be 1..15");
    end

    state_t      state;
    state_t      nxt;
    logic        ovr_pend;
    logic [1:0]  ovr_reg;
    logic [2:0]  gnt_q;
    logic [19:0] addr_q;
    logic [1:0]  used_q;

    logic        any_req;
    logic        grab;
    logic        fetch_first;
    logic [2:0]  win;
    logic [1:0]  dat_eff;
    logic [1:0]  sel;
    logic [15:0] sel_seg;
    logic [15:0] sel_ofs;
    logic [19:0] sel_addr;

    assign any_req = fetch_req | stk_req | dat_req;
    assign grab    = (state == IDLE) && any_req;

`ifdef SEG_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign fetch_first = fetch_req && (starve_cnt == 4'(STARVE_LIMIT));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            starve_cnt <= '0;
        end else if (grab) begin
            if (win[GNT_FETCH] || !fetch_req)
                starve_cnt <= '0;
            else
                starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign fetch_first = 1'b0;
`endif

    // Requests overlap, so this decoder is priority-ordered.
    always_comb begin
        win = '0;
        priority case (1'b1)
            fetch_first: win[GNT_FETCH] = 1'b1;
            stk_req:     win[GNT_STK]   = 1'b1;
            dat_req:     win[GNT_DAT]   = 1'b1;
            fetch_req:   win[GNT_FETCH] = 1'b1;
            default:     win = '0;
        endcase
    end

    // A prefix decoded in the grant cycle is bypassed straight in.
    always_comb begin
        dat_eff = dat_seg;
        if (ovr_set)
            dat_eff = ovr_seg;
        else if (ovr_pend)
            dat_eff = ovr_reg;
    end

    always_comb begin
        sel     = dat_eff;
        sel_ofs = dat_ofs;
        if (win[GNT_FETCH]) begin
            sel     = SEG_CS;
            sel_ofs = fetch_ofs;
        end else if (win[GNT_STK]) begin
            sel     = SEG_SS;
            sel_ofs = stk_ofs;
        end
    end

    always_comb begin
        sel_seg = seg_ds;
        unique case (sel)
            SEG_ES: sel_seg = seg_es;
            SEG_CS: sel_seg = seg_cs;
            SEG_SS: sel_seg = seg_ss;
            SEG_DS: sel_seg = seg_ds;
        endcase
    end

    phys_addr_gen u_pag (
        .seg  (sel_seg),
        .ofs  (sel_ofs),
        .addr (sel_addr)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (any_req) nxt = ISSUE;
            ISSUE:   if (bus.bus_ack) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gnt_q  <= '0;
            addr_q <= '0;
            used_q <= '0;
        end else if (grab) begin
            gnt_q  <= win;
            addr_q <= sel_addr;
            used_q <= sel;
        end else if (state == DONE) begin
            gnt_q  <= '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovr_pend <= 1'b0;
            ovr_reg  <= '0;
        end else begin
            if (ovr_set)
                ovr_reg <= ovr_seg;
            if (grab && win[GNT_DAT])
                ovr_pend <= 1'b0;
            else if (ovr_set)
                ovr_pend <= 1'b1;
        end
    end

    assign bus.bus_req  = (state == ISSUE);
    assign bus.bus_addr = addr_q;
    assign bus.grant    = gnt_q;
    assign bus.seg_used = used_q;
    assign bus.done     = (state == DONE) ? gnt_q : 3'b000;

endmodule

// File: tb/tb_seg_bus_arbiter.sv
// Scoreboard bench for seg_bus_arbiter: directed accesses push expected
// grant/address/segment; a monitor checks each bus cycle and done pulse.
module tb_seg_bus_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] seg_cs = '0, seg_ds = '0, seg_ss = '0, seg_es = '0;
    logic        fetch_req = 1'b0, stk_req = 1'b0, dat_req = 1'b0;
    logic [15:0] fetch_ofs = '0, stk_ofs = '0, dat_ofs = '0;
    logic [1:0]  dat_seg = 2'b11;
    logic        ovr_set = 1'b0;
    logic [1:0]  ovr_seg = 2'b00;

    seg_bus_if bus ();

    seg_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .seg_cs    (seg_cs),
        .seg_ds    (seg_ds),
        .seg_ss    (seg_ss),
        .seg_es    (seg_es),
        .fetch_req (fetch_req),
        .fetch_ofs (fetch_ofs),
        .stk_req   (stk_req),
        .stk_ofs   (stk_ofs),
        .dat_req   (dat_req),
        .dat_ofs   (dat_ofs),
        .dat_seg   (dat_seg),
        .ovr_set   (ovr_set),
        .ovr_seg   (ovr_seg),
        .bus       (bus.master)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  g;
        logic [19:0] a;
        logic [1:0]  s;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [2:0] G_F = 3'b001;
    localparam logic [2:0] G_S = 3'b010;
    localparam logic [2:0] G_D = 3'b100;

    task automatic check(input string name, input logic [19:0] act,
                         input logic [19:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic push(input logic [2:0] g, input logic [19:0] a,
                        input logic [1:0] s);
        exp_t e;
        e.g = g;
        e.a = a;
        e.s = s;
        exp_q.push_back(e);
    endtask

    // Bus slave: ack on the second cycle that bus_req is seen.
    int ack_cnt = 0;
    initial begin
        bus.bus_ack = 1'b0;
        forever begin
            @(negedge CLK);
            if (bus.bus_req) begin
                ack_cnt++;
                bus.bus_ack = (ack_cnt == 2);
                if (ack_cnt == 2) ack_cnt = 0;
            end else begin
                ack_cnt = 0;
                bus.bus_ack = 1'b0;
            end
        end
    end

    // Monitor: compares each new bus cycle and each done pulse.
    exp_t cur;
    logic have_cur  = 1'b0;
    logic prev_req  = 1'b0;
    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_req = 1'b0;
            end else begin
                if (bus.bus_req && !prev_req) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_cycle: got addr %h with no expectation", bus.bus_addr);
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1'b1;
                        check("grant", 20'(bus.grant), 20'(cur.g));
                        check("bus_addr", bus.bus_addr, cur.a);
                        check("seg_used", 20'(bus.seg_used), 20'(cur.s));
                    end
                end else if (bus.bus_req && have_cur) begin
                    check("addr_hold", bus.bus_addr, cur.a);
                end
                if (bus.done != 3'b000) begin
                    if (!have_cur) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL stray_done: got %b want none", bus.done);
                    end else begin
                        check("done", 20'(bus.done), 20'(cur.g));
                        check("req_low_in_done", 20'(bus.bus_req), 20'd0);
                        have_cur = 1'b0;
                    end
                end
                prev_req = bus.bus_req;
            end
        end
    end

    // Drops each request on its done pulse; returns once all are idle.
    task automatic run_idle(input int maxc);
        int n = 0;
        while ((fetch_req || stk_req || dat_req) && n < maxc) begin
            @(negedge CLK);
            if (bus.done[0]) fetch_req = 1'b0;
            if (bus.done[1]) stk_req   = 1'b0;
            if (bus.done[2]) dat_req   = 1'b0;
            n++;
        end
        if (n >= maxc) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got %0d cycles want <%0d", n, maxc);
            fetch_req = 1'b0;
            stk_req   = 1'b0;
            dat_req   = 1'b0;
        end
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        int n;
        int ndone;
        seg_cs    = 16'hF000;
        fetch_ofs = 16'hFFF0;
        seg_ss    = 16'hFFFF;
        stk_ofs   = 16'h0010;
        seg_ds    = 16'h2000;
        seg_es    = 16'h1000;
        dat_ofs   = 16'h0234;
        dat_seg   = 2'b11;

        repeat (2) @(negedge CLK);
        check("rst_bus_req", 20'(bus.bus_req), 20'd0);
        check("rst_grant", 20'(bus.grant), 20'd0);
        check("rst_done", 20'(bus.done), 20'd0);
        check("rst_addr", bus.bus_addr, 20'd0);
        check("rst_seg_used", 20'(bus.seg_used), 20'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Reset in the middle of a fetch, then the fetch is regranted.
        push(G_F, 20'hFFFF0, 2'b01);
        push(G_F, 20'hFFFF0, 2'b01);
        fetch_req = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!bus.bus_req && n < 20);
        #2 RST = 1'b1;
        #1;
        check("midrst_bus_req", 20'(bus.bus_req), 20'd0);
        check("midrst_grant", 20'(bus.grant), 20'd0);
        check("midrst_done", 20'(bus.done), 20'd0);
        check("midrst_addr", bus.bus_addr, 20'd0);
        @(negedge CLK);
        RST = 1'b0;
        run_idle(40);

        // Segment/offset changes during the access must not leak in.
        push(G_F, 20'hFFFF0, 2'b01);
        fetch_req = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!bus.bus_req && n < 20);
        seg_cs    = 16'h1234;
        fetch_ofs = 16'h0000;
        run_idle(40);
        seg_cs    = 16'hF000;
        fetch_ofs = 16'hFFF0;

        // Stack wrap past 1 MB.
        push(G_S, 20'h00000, 2'b10);
        stk_req = 1'b1;
        run_idle(40);

        // All three at once: stack, data, fetch.
        push(G_S, 20'h00000, 2'b10);
        push(G_D, 20'h20234, 2'b11);
        push(G_F, 20'hFFFF0, 2'b01);
        stk_req   = 1'b1;
        dat_req   = 1'b1;
        fetch_req = 1'b1;
        run_idle(60);

        // Pending ES override survives a stack grant, then used once.
        ovr_seg = 2'b00;
        ovr_set = 1'b1;
        @(negedge CLK);
        ovr_set = 1'b0;
        repeat (2) @(negedge CLK);
        push(G_S, 20'h00000, 2'b10);
        stk_req = 1'b1;
        run_idle(40);
        push(G_D, 20'h10234, 2'b00);
        dat_req = 1'b1;
        run_idle(40);
        push(G_D, 20'h20234, 2'b11);
        dat_req = 1'b1;
        run_idle(40);

        // Override decoded in the grant cycle is bypassed, not kept.
        push(G_D, 20'h00224, 2'b10);
        ovr_seg = 2'b10;
        ovr_set = 1'b1;
        dat_req = 1'b1;
        @(negedge CLK);
        ovr_set = 1'b0;
        run_idle(40);
        push(G_D, 20'h20234, 2'b11);
        dat_req = 1'b1;
        run_idle(40);

        // Stack held high with fetch waiting.
`ifdef SEG_ARB_STARVE_GUARD_EN
        repeat (4) push(G_S, 20'h00000, 2'b10);
        push(G_F, 20'hFFFF0, 2'b01);
`else
        repeat (5) push(G_S, 20'h00000, 2'b10);
        push(G_F, 20'hFFFF0, 2'b01);
`endif
        stk_req   = 1'b1;
        fetch_req = 1'b1;
        ndone = 0;
        n = 0;
        while ((stk_req || fetch_req) && n < 200) begin
            @(negedge CLK);
            if (bus.done != 3'b000) ndone++;
            if (bus.done[0]) fetch_req = 1'b0;
            if (ndone >= 5) stk_req = 1'b0;
            n++;
        end
        if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL starve_timeout: got %0d cycles want <200", n);
            stk_req   = 1'b0;
            fetch_req = 1'b0;
        end
        run_idle(40);

        check("queue_empty", 20'(exp_q.size()), 20'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
